// File: rtl/uart_txrx_if.sv
// Bundle of the UART transmit/receive signals between the user logic and uart_txrx.
// The DUT side uses the slave modport; the driving side uses master.
interface uart_txrx_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;

    modport slave (
        input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        output o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );

    modport master (
        output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
        input  o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Rx_DV, o_Rx_Byte
    );
endinterface

// File: rtl/uart_txrx.sv
// 8N1 UART with independent transmitter and receiver sharing one clock.
// The receiver samples each bit near its centre, timed from the middle of the start bit.
module uart_txrx #(
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    uart_txrx_if.slave  bus
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP
    } rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_serial_q, tx_serial_d;
    logic             tx_active_q, tx_active_d;
    logic             tx_done_q, tx_done_d;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_dv_q, rx_dv_d;

    // Transmit next state; outputs are decoded from the next state so they are registered
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        tx_done_d   = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (bus.i_Tx_DV) begin
                    tx_byte_d  = bus.i_Tx_Byte;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DONE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DONE: tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase

        case (tx_state_d)
            TX_START: begin
                tx_serial_d = 1'b0;
                tx_active_d = 1'b1;
            end
            TX_DATA: begin
                tx_serial_d = tx_byte_d[tx_bit_d];
                tx_active_d = 1'b1;
            end
            TX_STOP: tx_active_d = (tx_cnt_d != BIT_LAST);
            TX_DONE: tx_done_d   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Receive next state; every decision uses the synchronized line
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == BIT_MID) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d             = '0;
                    rx_shift_d[rx_bit_q] = rx_sync_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_bit_d   = '0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_CLEANUP;
                    if (rx_sync_q) begin
                        rx_byte_d = rx_shift_q;
                        rx_dv_d   = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_CLEANUP: rx_state_d = RX_IDLE;
            default:    rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_meta_q  <= bus.i_Rx_Serial;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    assign bus.o_Tx_Serial = tx_serial_q;
    assign bus.o_Tx_Active = tx_active_q;
    assign bus.o_Tx_Done   = tx_done_q;
    assign bus.o_Rx_DV     = rx_dv_q;
    assign bus.o_Rx_Byte   = rx_byte_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Testbench for uart_txrx: directed frames plus randomized loopback traffic,
// checked by scoreboards fed from an independent bit-level model of 8N1 framing.
module tb_uart_txrx;

    localparam int unsigned CLKS = 8;

    logic clk = 1'b0;
    logic rst;
    logic loopback;
    logic rx_drv;
    bit   txmon_en;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int rx_stop_cyc = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    always #5 clk = ~clk;

    uart_txrx_if bus();

    assign bus.i_Rx_Serial = loopback ? bus.o_Tx_Serial : rx_drv;

    uart_txrx #(.CLKS_PER_BIT(CLKS)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) if (bus.o_Tx_Done) done_cnt <= done_cnt + 1;

    // Receive scoreboard: every DV pulse must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && bus.o_Rx_DV) begin
            if (rx_exp_q.size() == 0) begin
                check("rx_dv unexpected", 32'd1, 32'd0);
            end else begin
                check("rx_byte", 32'(bus.o_Rx_Byte), 32'(rx_exp_q.pop_front()));
                if (!loopback)
                    check("rx_dv latency in stop bit",
                          32'((cycle - rx_stop_cyc >= 4) && (cycle - rx_stop_cyc <= 10)), 32'd1);
            end
        end
    end

    // Transmit scoreboard: decode the TX line as an ideal receiver sampling mid-bit
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (txmon_en && !rst && prev && !bus.o_Tx_Serial) begin
                repeat (CLKS / 2) @(negedge clk);
                check("tx start bit", 32'(bus.o_Tx_Serial), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    b[i] = bus.o_Tx_Serial;
                end
                repeat (CLKS) @(negedge clk);
                check("tx stop bit", 32'(bus.o_Tx_Serial), 32'd1);
                if (tx_exp_q.size() == 0) check("tx frame unexpected", 32'd1, 32'd0);
                else check("tx byte", 32'(b), 32'(tx_exp_q.pop_front()));
            end
            prev = bus.o_Tx_Serial;
        end
    end

    task automatic send_tx(input logic [7:0] b);
        int k;
        @(negedge clk);
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = b;
        tx_exp_q.push_back(b);
        if (loopback) rx_exp_q.push_back(b);
        done_exp++;
        @(negedge clk);
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'($urandom);
        k = 0;
        while (!bus.o_Tx_Done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tx done within budget", 32'(k < 200), 32'd1);
    endtask

    task automatic drive_bit(input logic v);
        rx_drv = v;
        repeat (CLKS) @(negedge clk);
    endtask

    // Caller is at a negedge; drives one frame then idle-high cycles
    task automatic drive_rx(input logic [7:0] b, input logic stop, input int idle);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx_stop_cyc = cycle;
        if (stop) rx_exp_q.push_back(b);
        drive_bit(stop);
        rx_drv = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        logic       exp_line;
        int         done_before;

        a5            = 8'hA5;
        rst           = 1'b1;
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = 8'h00;
        loopback      = 1'b0;
        rx_drv        = 1'b1;
        txmon_en      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset tx_serial", 32'(bus.o_Tx_Serial), 32'd1);
        check("reset tx_active", 32'(bus.o_Tx_Active), 32'd0);
        check("reset tx_done",   32'(bus.o_Tx_Done),   32'd0);
        check("reset rx_dv",     32'(bus.o_Rx_DV),     32'd0);
        check("reset rx_byte",   32'(bus.o_Rx_Byte),   32'd0);
        rst      = 1'b0;
        txmon_en = 1'b1;
        loopback = 1'b1;
        repeat (4) @(negedge clk);

        // Cycle-exact TX of 0xA5, with DV pulses mid-frame and during DONE that must be ignored
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = a5;
        tx_exp_q.push_back(a5);
        rx_exp_q.push_back(a5);
        done_exp++;
        for (int n = 0; n <= 90; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.i_Tx_DV   = 1'b0;
                bus.i_Tx_Byte = 8'($urandom);
            end
            if (n == 30 || n == 80) begin
                bus.i_Tx_DV   = 1'b1;
                bus.i_Tx_Byte = 8'h33;
            end else if (n == 31 || n == 81) begin
                bus.i_Tx_DV = 1'b0;
            end
            if (n < 8)       exp_line = 1'b0;
            else if (n < 72) exp_line = a5[(n - 8) / 8];
            else             exp_line = 1'b1;
            check($sformatf("a5 tx_serial n=%0d", n), 32'(bus.o_Tx_Serial), 32'(exp_line));
            check($sformatf("a5 tx_active n=%0d", n), 32'(bus.o_Tx_Active), 32'(n < 79));
            check($sformatf("a5 tx_done n=%0d", n),   32'(bus.o_Tx_Done),   32'(n == 80));
        end
        repeat (20) @(negedge clk);

        // Directed RX: clean frame, glitch, frame after glitch, framing error, back-to-back
        loopback = 1'b0;
        repeat (4) @(negedge clk);
        drive_rx(8'h3C, 1'b1, 12);
        check("rx_byte holds 0x3C", 32'(bus.o_Rx_Byte), 32'h3C);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        drive_rx(8'h55, 1'b1, 12);
        drive_rx(8'h81, 1'b0, 30);
        check("rx_byte after framing error", 32'(bus.o_Rx_Byte), 32'h55);
        for (int i = 0; i < 4; i++) drive_rx(8'($urandom), 1'b1, 0);
        repeat (20) @(negedge clk);

        // Loopback traffic: fixed corner bytes then random, each sent back-to-back
        loopback = 1'b1;
        repeat (4) @(negedge clk);
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h5A);
        for (int i = 0; i < 10; i++) send_tx(8'($urandom));
        repeat (30) @(negedge clk);

        // Reset in the middle of the data bits aborts the frame silently
        loopback = 1'b0;
        rx_drv   = 1'b1;
        txmon_en = 1'b0;
        done_before = done_cnt;
        @(negedge clk);
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = 8'h96;
        @(negedge clk);
        bus.i_Tx_DV = 1'b0;
        repeat (30) @(negedge clk);
        check("tx_active before reset", 32'(bus.o_Tx_Active), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-tx tx_serial", 32'(bus.o_Tx_Serial), 32'd1);
        check("reset mid-tx tx_active", 32'(bus.o_Tx_Active), 32'd0);
        check("reset mid-tx rx_byte",   32'(bus.o_Rx_Byte),   32'd0);
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.o_Tx_Serial !== 1'b1 || bus.o_Tx_Active !== 1'b0) begin
                check("tx idle after reset", 32'({bus.o_Tx_Serial, bus.o_Tx_Active}), 32'b10);
                break;
            end
        end
        check("no tx_done after reset", 32'(done_cnt), 32'(done_before));

        repeat (10) @(negedge clk);
        check("rx scoreboard drained", 32'(rx_exp_q.size()), 32'd0);
        check("tx scoreboard drained", 32'(tx_exp_q.size()), 32'd0);
        check("tx_done pulse count", 32'(done_cnt), 32'(done_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
UART_TXRX -- requirements
Module: uart_txrx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 234, giving clock cycles per serial bit (27 MHz / 115200 baud); legal range 4..65535.
REQ-002 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_Tx_DV, input, 1 bit: transmit request; one-cycle pulse.
REQ-005 The block SHALL have port i_Tx_Byte, input, 8 bits: byte to send, sampled with i_Tx_DV.
REQ-006 The block SHALL have port o_Tx_Serial, output, 1 bit: serial TX line, idle high.
REQ-007 The block SHALL have port o_Tx_Active, output, 1 bit: transmitter busy.
REQ-008 The block SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-009 The block SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial RX line.
REQ-010 The block SHALL have port o_Rx_DV, output, 1 bit: one-cycle pulse when a valid byte is received.
REQ-011 The block SHALL have port o_Rx_Byte, output, 8 bits: last received byte.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 TX states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 In IDLE, o_Tx_Serial=1 and o_Tx_Active=0. i_Tx_DV=1 latches i_Tx_Byte and moves to START; o_Tx_Active=1 from the next cycle.
REQ-015 START drives 0, DATA drives bits 0..7 of the latched byte in order, and STOP drives 1, each for CLKS_PER_BIT cycles, using an internal bit counter 0..7.
REQ-016 In the last STOP cycle, o_Tx_Active SHALL fall. DONE SHALL last one cycle with o_Tx_Done=1 and o_Tx_Serial=1, then return to IDLE.
REQ-017 i_Tx_DV SHALL be ignored while not in IDLE, including during DONE. Changes on i_Tx_Byte after latching SHALL have no effect.
REQ-018 i_Rx_Serial SHALL pass through a two-flop synchronizer; all RX decisions use the synchronized value.
REQ-019 RX states SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-020 RX IDLE: a synchronized 0 moves to START and clears the cycle counter.
REQ-021 RX START: at count (CLKS_PER_BIT-1)/2 (mid start bit), if the line is still 0, go to DATA and reset the counter; otherwise treat it as a glitch and return to IDLE.
REQ-022 RX DATA: every CLKS_PER_BIT cycles, sample one bit into shift position 0..7 (LSB first); after bit 7, go to STOP.
REQ-023 RX STOP: after CLKS_PER_BIT cycles (mid stop bit), if the line is 1, update o_Rx_Byte and pulse o_Rx_DV for exactly one cycle. If the line is 0 (framing error), discard the byte, leave o_Rx_Byte unchanged, and assert no o_Rx_DV. Then go to CLEANUP.
REQ-024 CLEANUP SHALL last one cycle and then go to IDLE. A following start bit SHALL be detected with no further idle time required.
REQ-025 o_Rx_Byte SHALL hold its value between receptions.
REQ-026 TX and RX SHALL operate fully independently and concurrently. Loopback of o_Tx_Serial to i_Rx_Serial SHALL recover every transmitted byte.

Reset
REQ-027 While i_Reset=1 at a clock edge: both FSMs go to IDLE, all counters clear, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=0, and synchronizer flops are set to 1.
REQ-028 Reset asserted mid-frame SHALL abort immediately. TX line returns high the next cycle, and no Done or DV pulse follows.

Verification (CLKS_PER_BIT=8 for simulation)
REQ-029 TX 0xA5: pulse i_Tx_DV -> line low 8 cycles, then 1,0,1,0,0,1,0,1 each 8 cycles, high 8 cycles; o_Tx_Done one pulse 81 cycles after the DV edge.
REQ-030 RX 0x3C: drive an ideal 8N1 frame -> exactly one o_Rx_DV pulse with o_Rx_Byte=0x3C, about 4+2 cycles into the stop bit.
REQ-031 Glitch: i_Rx_Serial low for 2 cycles then high -> no o_Rx_DV, RX returns to IDLE; a subsequent 0x55 frame is received correctly.
REQ-032 Framing error: 0x81 frame with stop bit 0 -> no o_Rx_DV, o_Rx_Byte keeps its previous value.
REQ-033 Busy/back-to-back: second i_Tx_DV mid-frame is ignored; loopback of 0x00, 0xFF, 0x5A sent consecutively -> three DV pulses with matching bytes.
REQ-034 Reset mid-TX: assert i_Reset during DATA -> next cycle o_Tx_Serial=1 and o_Tx_Active=0, with no o_Tx_Done pulse.
